seq_muldiv_unit: RTL

Dedicated multi-cycle arithmetic unit that multiplies by repeated addition or divides by repeated subtraction. It reuses the add/subtract datapath style already in the microprocessor: operand registers, an accumulator, an adder/subtractor and a small control FSM. It is parametrised in operand width, adds a multiply/divide mode, and adds a start/busy/done handshake. It sits beside the main datapath as a coprocessor, driven by the control unit through start and done.

---
 rtl/seq_muldiv_unit_if.sv | 23 ++
 rtl/seq_muldiv_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/seq_muldiv_unit_if.sv
// Start/busy/done handshake and operand/result bus of the sequential mul/div coprocessor.
interface seq_muldiv_unit_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 div_by_zero;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/seq_muldiv_unit.sv
// Multi-cycle unsigned multiplier (repeated add) / divider (repeated subtract)
// with a start/busy/done handshake; divide result is {remainder, quotient}.
module seq_muldiv_unit #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_muldiv_unit_if.slave    bus
);
  localparam int RW = 2*WIDTH;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           r_state, w_state_nxt;
  req_t             r_req, w_req_nxt;
  logic [RW-1:0]    r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_quo, w_quo_nxt;
  logic [RW-1:0]    r_result, w_result_nxt;
  logic             r_dbz, w_dbz_nxt;

  logic [RW-1:0]    w_a_ext, w_b_ext, w_sum, w_diff;
  logic             w_ge;

  assign w_a_ext = {{WIDTH{1'b0}}, r_req.a};
  assign w_b_ext = {{WIDTH{1'b0}}, r_req.b};
  assign w_sum   = r_acc + w_a_ext;
  assign w_diff  = r_acc - w_b_ext;
  assign w_ge    = (r_acc >= w_b_ext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_req    <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_acc    <= w_acc_nxt;
      r_quo    <= w_quo_nxt;
      r_result <= w_result_nxt;
      r_dbz    <= w_dbz_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_acc_nxt    = r_acc;
    w_quo_nxt    = r_quo;
    w_result_nxt = r_result;
    w_dbz_nxt    = r_dbz;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_req_nxt   = '{mode: bus.mode, a: bus.a, b: bus.b};
          w_acc_nxt   = bus.mode ? {{WIDTH{1'b0}}, bus.a} : '0;
          w_quo_nxt   = '0;
          w_dbz_nxt   = 1'b0;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: w_state_nxt = S_RUN;
      S_RUN: begin
        // b=0 resolves after one RUN cycle so it retires two edges after start
        if (r_req.b == '0) begin
          w_result_nxt = r_req.mode ? '1 : '0;
          w_dbz_nxt    = r_req.mode;
          w_state_nxt  = S_DONE;
        end else if (!r_req.mode) begin
          w_acc_nxt   = w_sum;
          w_req_nxt.b = r_req.b - ONE;
          if (r_req.b == ONE) begin
            w_result_nxt = w_sum;
            w_state_nxt  = S_DONE;
          end
        end else if (w_ge) begin
          w_acc_nxt = w_diff;
          w_quo_nxt = r_quo + ONE;
        end else begin
          w_result_nxt = {r_acc[WIDTH-1:0], r_quo};
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy        = (r_state == S_CHECK) || (r_state == S_RUN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.result      = r_result;
  assign bus.div_by_zero = r_dbz;
endmodule
